// File: rtl/time_syn_tx_if.sv
// rtl/time_syn_tx_if.sv - control-frame transmit stream interface
interface time_syn_tx_if;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;
    logic        tready;

    modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/time_syn_tx.sv
// rtl/time_syn_tx.sv - timestamp / standard-time / return / slot-ID control frame transmitter
// Slot-ID frame generation is built only when TIME_SYN_TX_SLOT_EN is defined.
module time_syn_tx #(
    parameter logic [15:0] P_SLOT_ID_TYPE = 16'hff03,
    parameter logic [47:0] P_SRC_MAC      = 48'h00_0a_35_00_00_01,
    parameter logic [63:0] P_TS_COMP      = 64'd0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [63:0]   i_local_time,
    input  logic          i_send_ts,
    input  logic          i_send_std,
    input  logic [63:0]   i_std_time,
    input  logic          i_send_return,
    input  logic [63:0]   i_return_ts,
    input  logic          i_send_slot,
    input  logic          i_slot_id,
    input  logic [47:0]   i_dest_mac,
    output logic          o_busy,
    output logic          o_frame_done,
    time_syn_tx_if.master m_ctrl_tx_axis
);
    localparam logic [63:0] PFX_TS  = 64'h66;
    localparam logic [63:0] PFX_STD = 64'h88;
    localparam logic [63:0] PFX_RET = 64'h55;

`ifdef TIME_SYN_TX_SLOT_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, SLOT} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t      state;
    logic        pend_ts;
    logic        pend_std;
    logic        pend_ret;
    logic [63:0] lat_std;
    logic [63:0] lat_ret;
    logic [63:0] pay;
    logic        pay_is_ts;
    logic        tvalid;
    logic        tlast;
    logic [63:0] tdata;
    logic        win_slot;
    logic        win_ret;
    logic        win_ts;
    logic        win_std;
    logic        arb;

`ifdef TIME_SYN_TX_SLOT_EN
    logic        pend_slot;
    logic        lat_sid;
    logic [47:0] lat_mac;
    logic [2:0]  beat;
    assign win_slot = pend_slot;
`else
    logic slot_unused;
    assign win_slot    = 1'b0;
    assign slot_unused = &{1'b0, i_send_slot, i_slot_id, i_dest_mac};
`endif

    assign arb = (state == IDLE);

    always_comb begin
        win_ret = ~win_slot & pend_ret;
        win_ts  = ~win_slot & ~pend_ret & pend_ts;
        win_std = ~win_slot & ~pend_ret & ~pend_ts & pend_std;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pend_ts      <= 1'b0;
            pend_std     <= 1'b0;
            pend_ret     <= 1'b0;
            lat_std      <= 64'd0;
            lat_ret      <= 64'd0;
            pay          <= 64'd0;
            pay_is_ts    <= 1'b0;
            tvalid       <= 1'b0;
            tlast        <= 1'b0;
            tdata        <= 64'd0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
`ifdef TIME_SYN_TX_SLOT_EN
            pend_slot    <= 1'b0;
            lat_sid      <= 1'b0;
            lat_mac      <= 48'd0;
            beat         <= 3'd0;
`endif
        end else begin
            o_frame_done <= 1'b0;

            // A pulse in the same cycle as the clear re-arms the flag for one more frame.
            pend_ts  <= i_send_ts     | (pend_ts  & ~(arb & win_ts));
            pend_std <= i_send_std    | (pend_std & ~(arb & win_std));
            pend_ret <= i_send_return | (pend_ret & ~(arb & win_ret));
            if (i_send_std)    lat_std <= i_std_time;
            if (i_send_return) lat_ret <= i_return_ts;
`ifdef TIME_SYN_TX_SLOT_EN
            pend_slot <= i_send_slot | (pend_slot & ~(arb & win_slot));
            if (i_send_slot) begin
                lat_mac <= i_dest_mac;
                lat_sid <= i_slot_id;
            end
`endif

            case (state)
                IDLE: begin
`ifdef TIME_SYN_TX_SLOT_EN
                    if (win_slot) begin
                        state  <= SLOT;
                        tvalid <= 1'b1;
                        tlast  <= 1'b0;
                        o_busy <= 1'b1;
                        beat   <= 3'd0;
                        tdata  <= {P_SRC_MAC, lat_mac[47:32]};
                        pay    <= {lat_mac[31:0], P_SLOT_ID_TYPE, 15'd0, lat_sid};
                    end else
`endif
                    if (win_ret | win_ts | win_std) begin
                        state     <= HDR;
                        tvalid    <= 1'b1;
                        tlast     <= 1'b0;
                        o_busy    <= 1'b1;
                        pay_is_ts <= win_ts;
                        tdata     <= win_ret ? PFX_RET : (win_ts ? PFX_TS : PFX_STD);
                        pay       <= win_ret ? lat_ret : lat_std;
                    end
                end
                HDR: begin
                    if (m_ctrl_tx_axis.tready) begin
                        state <= PAY;
                        tdata <= pay_is_ts ? (i_local_time + P_TS_COMP) : pay;
                        tlast <= 1'b1;
                    end
                end
                PAY: begin
                    if (m_ctrl_tx_axis.tready) begin
                        state        <= IDLE;
                        tvalid       <= 1'b0;
                        tlast        <= 1'b0;
                        tdata        <= 64'd0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end
                end
`ifdef TIME_SYN_TX_SLOT_EN
                SLOT: begin
                    if (m_ctrl_tx_axis.tready) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) begin
                            state        <= IDLE;
                            tvalid       <= 1'b0;
                            tlast        <= 1'b0;
                            tdata        <= 64'd0;
                            o_busy       <= 1'b0;
                            o_frame_done <= 1'b1;
                        end else begin
                            tdata <= (beat == 3'd0) ? pay : 64'd0;
                            tlast <= (beat == 3'd6);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign m_ctrl_tx_axis.tvalid = tvalid;
    assign m_ctrl_tx_axis.tdata  = tdata;
    assign m_ctrl_tx_axis.tlast  = tlast;
    assign m_ctrl_tx_axis.tkeep  = 8'hFF;
    assign m_ctrl_tx_axis.tuser  = 1'b0;
endmodule

// File: tb/tb_time_syn_tx.sv
// tb/tb_time_syn_tx.sv - self-checking bench for time_syn_tx
module tb_time_syn_tx;
`ifdef TIME_SYN_TX_SLOT_EN
    localparam bit SLOT_EN = 1'b1;
`else
    localparam bit SLOT_EN = 1'b0;
`endif
    localparam logic [63:0] TS_COMP   = 64'd10;
    localparam logic [47:0] SRC_MAC   = 48'h00_0a_35_00_00_01;
    localparam logic [15:0] SLOT_TYPE = 16'hff03;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_local_time;
    logic        i_send_ts, i_send_std, i_send_return, i_send_slot;
    logic [63:0] i_std_time, i_return_ts;
    logic        i_slot_id;
    logic [47:0] i_dest_mac;
    logic        o_busy, o_frame_done;

    time_syn_tx_if axis();

    time_syn_tx #(.P_TS_COMP(TS_COMP)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_local_time  (i_local_time),
        .i_send_ts     (i_send_ts),
        .i_send_std    (i_send_std),
        .i_std_time    (i_std_time),
        .i_send_return (i_send_return),
        .i_return_ts   (i_return_ts),
        .i_send_slot   (i_send_slot),
        .i_slot_id     (i_slot_id),
        .i_dest_mac    (i_dest_mac),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .m_ctrl_tx_axis(axis)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request classes 0 slot, 1 return, 2 ts, 3 std (index = priority).
    logic [3:0]  m_fq, m_pp;
    logic [63:0] m_lstd, m_lret, m_pstd, m_pret;
    logic [47:0] m_lmac, m_pmac;
    logic        m_lsid, m_psid;
    logic [63:0] m_exp[$];
    int          m_cls, m_beat;
    bit          m_in_frame, m_stall, m_last_hs, m_busy_prev;
    logic [63:0] m_sdata;
    logic        m_slast;
    logic [63:0] beats[$];
    int          order[$];
    int          done_cnt = 0;

    always @(negedge i_clk) begin
        logic [3:0] nf;
        int win;
        if (i_rst) begin
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tdata", axis.tdata, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_frame_done, 0);
            m_fq = 0; m_pp = 0;
            m_lstd = 0; m_lret = 0; m_lmac = 0; m_lsid = 0;
            m_in_frame = 0; m_stall = 0; m_last_hs = 0; m_busy_prev = 0;
        end else begin
            nf = m_fq | m_pp;
            if (!m_in_frame && !m_busy_prev && m_fq != 0)
                chk("start_latency", axis.tvalid, 1);
            if (axis.tvalid && !m_in_frame) begin
                chk("gap", m_busy_prev, 0);
                win = -1;
                for (int k = 3; k >= 0; k--) if (m_fq[k]) win = k;
                chk("spurious_frame", win < 0, 0);
                m_exp.delete();
                case (win)
                    0: begin
                        m_exp.push_back({SRC_MAC, m_lmac[47:32]});
                        m_exp.push_back({m_lmac[31:0], SLOT_TYPE, 15'd0, m_lsid});
                        repeat (6) m_exp.push_back(64'd0);
                    end
                    1: begin m_exp.push_back(64'h55); m_exp.push_back(m_lret); end
                    2: begin m_exp.push_back(64'h66); m_exp.push_back(64'd0); end
                    3: begin m_exp.push_back(64'h88); m_exp.push_back(m_lstd); end
                    default: begin m_exp.push_back(64'd0); m_exp.push_back(64'd0); end
                endcase
                if (win >= 0) nf[win] = m_pp[win];
                m_cls = win; m_beat = 0; m_in_frame = 1;
            end
            chk("frame_done", o_frame_done, m_last_hs);
            if (o_frame_done) done_cnt++;
            chk("busy", o_busy, axis.tvalid);
            m_last_hs = 0;
            if (m_in_frame) begin
                chk("tvalid_hold", axis.tvalid, 1);
                if (!axis.tvalid) m_in_frame = 0;
                else begin
                    chk("tkeep", axis.tkeep, 8'hFF);
                    chk("tuser", axis.tuser, 0);
                    if (m_stall) begin
                        chk("stall_tdata", axis.tdata, m_sdata);
                        chk("stall_tlast", axis.tlast, m_slast);
                    end
                    if (axis.tready) begin
                        if (m_cls == 2 && m_beat == 0) m_exp[1] = i_local_time + TS_COMP;
                        chk("tdata", axis.tdata, m_exp[m_beat]);
                        chk("tlast", axis.tlast, m_beat == m_exp.size() - 1);
                        beats.push_back(axis.tdata);
                        m_beat++;
                        if (m_beat == m_exp.size()) begin
                            m_in_frame = 0;
                            m_last_hs = 1;
                            order.push_back(m_cls);
                        end
                    end
                end
            end
            m_stall = axis.tvalid && !axis.tready;
            m_sdata = axis.tdata;
            m_slast = axis.tlast;
            m_busy_prev = o_busy;
            if (m_pp[3]) m_lstd = m_pstd;
            if (m_pp[1]) m_lret = m_pret;
            if (m_pp[0]) begin m_lmac = m_pmac; m_lsid = m_psid; end
            m_fq = nf;
            m_pp = {i_send_std, i_send_ts, i_send_return, i_send_slot & SLOT_EN};
            m_pstd = i_std_time; m_pret = i_return_ts;
            m_pmac = i_dest_mac; m_psid = i_slot_id;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] req);
        i_send_slot = req[0]; i_send_return = req[1]; i_send_ts = req[2]; i_send_std = req[3];
        step();
        i_send_slot = 0; i_send_return = 0; i_send_ts = 0; i_send_std = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((m_in_frame || m_fq != 0 || m_pp != 0 || axis.tvalid || o_busy) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n >= maxc, 0);
        step();
        step();
    endtask

    typedef struct packed {
        logic [1:0]  cls;
        logic [63:0] payload;
        logic [63:0] lt;
        logic [63:0] w0;
        logic [63:0] w1;
    } vec_t;

    vec_t        vt[6];
    logic [63:0] es[$];
    int          eo[$];
    int          b0, d0, o0, n, tgt;

    initial begin
        vt[0] = '{2'd3, 64'h1234,                64'd0,                 64'h88, 64'h1234};
        vt[1] = '{2'd2, 64'd0,                   64'd1000,              64'h66, 64'd1010};
        vt[2] = '{2'd1, 64'h0000_0000_dead_beef, 64'd0,                 64'h55, 64'h0000_0000_dead_beef};
        vt[3] = '{2'd2, 64'd0,                   64'hffff_ffff_ffff_fffa, 64'h66, 64'd4};
        vt[4] = '{2'd3, 64'hffff_ffff_ffff_ffff, 64'd0,                 64'h88, 64'hffff_ffff_ffff_ffff};
        vt[5] = '{2'd1, 64'd0,                   64'd0,                 64'h55, 64'd0};

        i_rst = 1; i_local_time = 0;
        i_send_ts = 0; i_send_std = 0; i_send_return = 0; i_send_slot = 0;
        i_std_time = 0; i_return_ts = 0; i_slot_id = 0; i_dest_mac = 0;
        axis.tready = 1;
        repeat (3) step();
        i_rst = 0;
        step();

        for (int i = 0; i < 6; i++) begin
            b0 = beats.size(); d0 = done_cnt;
            i_local_time = vt[i].lt; i_std_time = vt[i].payload; i_return_ts = vt[i].payload;
            pulse(4'b0001 << vt[i].cls);
            wait_idle(50);
            chk($sformatf("vec%0d_len", i), beats.size() - b0, 2);
            if (beats.size() >= b0 + 2) begin
                chk($sformatf("vec%0d_w0", i), beats[b0], vt[i].w0);
                chk($sformatf("vec%0d_w1", i), beats[b0+1], vt[i].w1);
            end
            chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
        end

        b0 = beats.size();
        i_slot_id = 1; i_dest_mac = 48'hAABB_CCDD_EEFF;
        pulse(4'b0001);
        wait_idle(60);
        if (SLOT_EN) begin
            es.push_back(64'h000a_3500_0001_aabb);
            es.push_back(64'hccdd_eeff_ff03_0001);
            repeat (6) es.push_back(64'd0);
        end
        chk("slot_len", beats.size() - b0, es.size());
        for (int i = 0; i < es.size(); i++)
            if (b0 + i < beats.size()) chk($sformatf("slot_w%0d", i), beats[b0+i], es[i]);

        o0 = order.size();
        i_std_time = 64'h1111; i_return_ts = 64'h2222; i_dest_mac = 48'h0102_0304_0506;
        pulse(4'b1011);
        wait_idle(100);
        if (SLOT_EN) eo.push_back(0);
        eo.push_back(1);
        eo.push_back(3);
        chk("order_len", order.size() - o0, eo.size());
        for (int i = 0; i < eo.size(); i++)
            if (o0 + i < order.size()) chk($sformatf("order%0d", i), order[o0+i], eo[i]);

        axis.tready = 0;
        i_return_ts = 64'hcafe_f00d_1234_5678;
        b0 = beats.size(); d0 = done_cnt;
        pulse(4'b0010);
        n = 0;
        while (!m_in_frame && n < 20) begin step(); n++; end
        chk("stall_start_timeout", n >= 20, 0);
        axis.tready = 1;
        step();
        axis.tready = 0;
        repeat (5) step();
        chk("stall_no_early_done", done_cnt - d0, 0);
        axis.tready = 1;
        wait_idle(20);
        chk("stall_done_once", done_cnt - d0, 1);
        chk("stall_len", beats.size() - b0, 2);
        if (beats.size() >= b0 + 2) chk("stall_w1", beats[b0+1], 64'hcafe_f00d_1234_5678);

        i_std_time = 64'h0bad;
        pulse(4'b1001);
        tgt = SLOT_EN ? 3 : 1;
        n = 0;
        while (!(m_in_frame && m_beat == tgt) && n < 40) begin step(); n++; end
        chk("abort_reach_timeout", n >= 40, 0);
        i_rst = 1;
        #1;
        chk("abort_tvalid", axis.tvalid, 0);
        chk("abort_tlast", axis.tlast, 0);
        step();
        step();
        i_rst = 0;
        step();
        b0 = beats.size(); d0 = done_cnt;
        i_std_time = 64'h5151;
        pulse(4'b1000);
        wait_idle(30);
        chk("post_rst_len", beats.size() - b0, 2);
        if (beats.size() >= b0 + 2) begin
            chk("post_rst_w0", beats[b0], 64'h88);
            chk("post_rst_w1", beats[b0+1], 64'h5151);
        end
        chk("post_rst_done", done_cnt - d0, 1);

        o0 = order.size();
        for (int c = 0; c < 3000; c++) begin
            i_local_time  = i_local_time + 64'($urandom_range(1, 3));
            axis.tready   = ($urandom_range(0, 3) != 0);
            i_send_std    = ($urandom_range(0, 11) == 0);
            i_send_ts     = ($urandom_range(0, 11) == 0);
            i_send_return = ($urandom_range(0, 11) == 0);
            i_send_slot   = ($urandom_range(0, 11) == 0);
            i_std_time    = {$urandom(), $urandom()};
            i_return_ts   = {$urandom(), $urandom()};
            i_slot_id     = 1'($urandom_range(0, 1));
            i_dest_mac    = {16'($urandom()), $urandom()};
            step();
        end
        i_send_std = 0; i_send_ts = 0; i_send_return = 0; i_send_slot = 0;
        axis.tready = 1;
        wait_idle(200);
        chk("random_frames_seen", (order.size() - o0) > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/time_syn_tx.md
TIME_SYN_TX -- requirements
Module: time_syn_tx

Interface
REQ-001 Parameter P_SLOT_ID_TYPE, default 16'hff03, ethertype carried in slot-ID frames.
REQ-002 Parameter P_SRC_MAC, default 48'h00_0a_35_00_00_01, source MAC placed in slot-ID frames.
REQ-003 Parameter P_TS_COMP, default 64'd0, constant added to the sampled local time in timestamp frames.
REQ-004 i_clk  in  1  clock; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_local_time  in  64  free-running local time.
REQ-006 i_send_ts  in  1  pulse, request timestamp frame.
REQ-007 i_send_std  in  1  pulse, request standard-time frame; i_std_time  in  64  its payload.
REQ-008 i_send_return  in  1  pulse, request return frame; i_return_ts  in  64  its payload.
REQ-009 i_send_slot  in  1  pulse, request slot-ID frame; i_slot_id  in  1  slot ID; i_dest_mac  in  48  destination ToR MAC.
REQ-010 o_busy  out  1  frame in progress; o_frame_done  out  1  one-cycle pulse on each frame's tlast handshake.
REQ-011 m_ctrl_tx_axis_tvalid out 1, tdata out 64, tlast out 1, tkeep out 8, tuser out 1; m_ctrl_tx_axis_tready in 1.

Function
REQ-012 Each request class has a pending flag, set on its pulse and cleared in the cycle its frame's word 0 is first presented.
REQ-013 Payload inputs are latched on the request pulse; a repeat pulse while pending overwrites the latch (latest wins), with no second frame.
REQ-014 A pulse arriving in the same cycle its flag clears sets the flag again, yielding one additional frame.
REQ-015 FSM states: IDLE, HDR, PAY, SLOT; only IDLE arbitrates.
REQ-016 Fixed priority in IDLE: slot > return > ts > std; IDLE -> SLOT for slot, otherwise -> HDR; the winner's word 0 is presented the cycle after IDLE.
REQ-017 Sync frames are 2 words: word 0 = prefix, tlast=0; word 1 = payload, tlast=1.
REQ-018 Prefixes: ts 64'h66, std 64'h88, return 64'h55 (zero-extended).
REQ-019 Ts payload = i_local_time sampled in the cycle word 0 handshakes, plus P_TS_COMP, modulo 2^64; std and return payloads are the latched values.
REQ-020 Slot frame is 8 words, tlast on word 7.
REQ-021 Slot word 0 = {P_SRC_MAC, i_dest_mac[47:32]}.
REQ-022 Slot word 1 = {i_dest_mac[31:0], P_SLOT_ID_TYPE, 15'd0, slot_id}.
REQ-023 Slot words 2-7 = 64'd0.
REQ-024 tkeep = 8'hFF and tuser = 0 on every word.
REQ-025 tvalid stays high and tdata/tlast stay stable until tready; tready low stalls with no data change.
REQ-026 A beat advances only on tvalid&tready; on the tlast beat: o_frame_done=1, FSM -> IDLE.
REQ-027 Back-to-back frames: at least one IDLE cycle between them.
REQ-028 o_busy = 1 in HDR, PAY and SLOT; o_busy = 0 in IDLE.

Reset
REQ-029 Reset forces IDLE and clears all pending flags, latches, beat counter, tvalid, tlast, tdata, o_busy and o_frame_done to 0.
REQ-030 Reset mid-frame aborts the frame immediately with no tlast emitted; after release, behaviour is as from power-up.

Configuration
REQ-031 With macro TIME_SYN_TX_SLOT_EN defined, slot-ID frame generation is present as specified.
REQ-032 Without TIME_SYN_TX_SLOT_EN, the slot logic and SLOT state are removed; i_send_slot, i_slot_id and i_dest_mac remain ports but are ignored.

Verification
REQ-033 Scenario: tready=1, i_send_std with i_std_time=64'h1234 -> two beats, 64'h88 then 64'h1234 with tlast=1, then one o_frame_done pulse.
REQ-034 Scenario: i_send_ts, P_TS_COMP=10, tready=1, i_local_time=1000 at the word 0 handshake -> word 1 = 1010.
REQ-035 Scenario: i_send_slot, i_slot_id=1, i_dest_mac=48'hAABB_CCDD_EEFF -> 8 beats; word0[15:0]=16'hAABB; word1=64'hCCDDEEFF_FF03_0001; tlast only on word 7.
REQ-036 Scenario: i_send_std, i_send_return and i_send_slot pulsed in the same cycle -> frame order slot, return, std, each separated by at least one IDLE cycle.
REQ-037 Scenario: tready held low for 5 cycles on word 1 of a return frame -> tdata/tlast stable throughout; exactly one o_frame_done pulse after tready rises.
REQ-038 Scenario: i_rst asserted during slot word 3 -> tvalid low in the same cycle; after release, a new std request produces a clean 2-beat frame.
